// File: rtl/fip_add_arbiter_if.sv
// Handshake bundle between the intersection units, the shared Q16.16 adder and
// the downstream result consumer.
interface fip_add_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [DATA_W*N_REQ-1:0] req_x;
    logic [DATA_W*N_REQ-1:0] req_y;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_W-1:0]       rsp_sum;
    logic                    rsp_overflow;
    logic [ID_W-1:0]         rsp_id;

    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_overflow, rsp_id
    );

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_overflow, rsp_id
    );
endinterface

// File: rtl/fip_add_arbiter.sv
// Round-robin front end for one shared Q16.16 adder: two pipeline stages,
// valid/ready on both sides and a saturating overflow event counter.
module fip_add_arbiter #(
    parameter int N_REQ    = 4,
    parameter int SATURATE = 0,
    parameter int ID_W     = 2,
    parameter int DATA_W   = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    fip_add_arbiter_if.slave  bus,
    output logic [15:0]       ovf_count_o
);

    localparam logic [ID_W-1:0] PTR_RST = ID_W'(N_REQ - 1);

    // Returns {overflow, sum}; wraps or clamps depending on SATURATE.
    function automatic logic [DATA_W:0] add_q16(input logic signed [DATA_W-1:0] a,
                                                input logic signed [DATA_W-1:0] b);
        logic signed [DATA_W:0] s;
        logic                   ovf;
        logic [DATA_W-1:0]      res;
        s   = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        ovf = s[DATA_W] ^ s[DATA_W-1];
        res = s[DATA_W-1:0];
        if (SATURATE != 0 && ovf) begin
            res = s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
        return {ovf, res};
    endfunction

    logic                     vld_p1_q, vld_p1_d;
    logic signed [DATA_W-1:0] x_p1_q, x_p1_d;
    logic signed [DATA_W-1:0] y_p1_q, y_p1_d;
    logic [ID_W-1:0]          id_p1_q, id_p1_d;
    logic                     vld_p2_q, vld_p2_d;
    logic signed [DATA_W-1:0] sum_p2_q, sum_p2_d;
    logic                     ovf_p2_q, ovf_p2_d;
    logic [ID_W-1:0]          id_p2_q, id_p2_d;
    logic [ID_W-1:0]          ptr_q, ptr_d;
    logic [15:0]              ovf_cnt_q, ovf_cnt_d;

    logic                     adv1, adv2, accept;
    logic                     gnt_vld;
    logic [ID_W-1:0]          gnt_idx, cand;
    logic [N_REQ-1:0]         ready;
    logic signed [DATA_W-1:0] x_sel, y_sel;

    assign adv2   = !vld_p2_q || bus.rsp_ready;
    assign adv1   = !vld_p1_q || adv2;
    assign accept = adv1 && gnt_vld && !reset_i;

    // Search starts one past the last granted requester.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(ptr_q) + k) % N_REQ);
            if (!gnt_vld && bus.req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        ready = '0;
        if (accept) begin
            ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        x_sel = '0;
        y_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                x_sel = bus.req_x[i*DATA_W +: DATA_W];
                y_sel = bus.req_y[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        // S1: operand capture
        vld_p1_d = vld_p1_q;
        x_p1_d   = x_p1_q;
        y_p1_d   = y_p1_q;
        id_p1_d  = id_p1_q;
        if (adv1) begin
            vld_p1_d = accept;
            if (accept) begin
                x_p1_d  = x_sel;
                y_p1_d  = y_sel;
                id_p1_d = gnt_idx;
            end
        end
        // S2: add result
        vld_p2_d = vld_p2_q;
        sum_p2_d = sum_p2_q;
        ovf_p2_d = ovf_p2_q;
        id_p2_d  = id_p2_q;
        if (adv2) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                {ovf_p2_d, sum_p2_d} = add_q16(x_p1_q, y_p1_q);
                id_p2_d              = id_p1_q;
            end
        end
        ptr_d     = accept ? gnt_idx : ptr_q;
        ovf_cnt_d = ovf_cnt_q;
        if (vld_p2_q && bus.rsp_ready && ovf_p2_q && ovf_cnt_q != 16'hFFFF) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            sum_p2_q  <= '0;
            ovf_p2_q  <= 1'b0;
            id_p2_q   <= '0;
            ptr_q     <= PTR_RST;
            ovf_cnt_q <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            sum_p2_q  <= sum_p2_d;
            ovf_p2_q  <= ovf_p2_d;
            id_p2_q   <= id_p2_d;
            ptr_q     <= ptr_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    // Operand registers are only meaningful while vld_p1_q is set.
    always_ff @(posedge clk_i) begin
        x_p1_q  <= x_p1_d;
        y_p1_q  <= y_p1_d;
        id_p1_q <= id_p1_d;
    end

    assign bus.req_ready    = ready;
    assign bus.rsp_valid    = vld_p2_q;
    assign bus.rsp_sum      = sum_p2_q;
    assign bus.rsp_overflow = ovf_p2_q;
    assign bus.rsp_id       = id_p2_q;
    assign ovf_count_o      = ovf_cnt_q;

endmodule

// File: tb/tb_fip_add_arbiter.sv
// Scoreboard bench for fip_add_arbiter: wrapping and saturating instances share
// the same stimulus and are checked against a latency/occupancy reference model.
module tb_fip_add_arbiter;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ovf0, ovf1;

    fip_add_arbiter_if #(.N_REQ(N), .ID_W(2), .DATA_W(32)) ifa ();
    fip_add_arbiter_if #(.N_REQ(N), .ID_W(2), .DATA_W(32)) ifb ();

    assign ifb.req_valid = ifa.req_valid;
    assign ifb.req_x     = ifa.req_x;
    assign ifb.req_y     = ifa.req_y;
    assign ifb.rsp_ready = ifa.rsp_ready;

    fip_add_arbiter #(.N_REQ(N), .SATURATE(0), .ID_W(2), .DATA_W(32)) dut0 (
        .clk_i(clk), .reset_i(reset), .bus(ifa), .ovf_count_o(ovf0));
    fip_add_arbiter #(.N_REQ(N), .SATURATE(1), .ID_W(2), .DATA_W(32)) dut1 (
        .clk_i(clk), .reset_i(reset), .bus(ifb), .ovf_count_o(ovf1));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        int          id;
        int          acc;
    } ent_t;

    int          nerr = 0;
    int          nchk = 0;
    int          cyc = 0;
    int          nresp = 0;
    ent_t        sb[$];
    int          gnt_log[$];
    int          mptr = N - 1;
    int          mcnt = 0;
    logic [N-1:0] acc_mask = '0;
    bit          hold = 0;
    logic [31:0] hs0, hs1;
    logic        ho;
    logic [1:0]  hid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Exact-integer reference for the Q16.16 add.
    function automatic logic [31:0] ref_sum(input logic [31:0] x, input logic [31:0] y,
                                            input bit sat, output bit ovf);
        longint s;
        longint maxv;
        longint minv;
        maxv = 64'sd2147483647;
        minv = -64'sd2147483648;
        s    = longint'($signed(x)) + longint'($signed(y));
        ovf  = (s > maxv) || (s < minv);
        if (sat && ovf) return (s > 0) ? 32'h7FFFFFFF : 32'h80000000;
        return s[31:0];
    endfunction

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        int           g;
        int           idx;
        bit           adv;
        bit           exp_v;
        bit           o;
        logic [31:0]  e0, e1;
        ent_t         e;
        cyc++;
        acc_mask = ifa.req_valid & ifa.req_ready;
        if (reset) begin
            chk("req_ready_in_reset_a", 32'(ifa.req_ready), 32'h0);
            chk("req_ready_in_reset_b", 32'(ifb.req_ready), 32'h0);
            sb.delete();
            mptr = N - 1;
            mcnt = 0;
            hold = 0;
        end else begin
            chk("ovf_count_a", 32'(ovf0), 32'(mcnt));
            chk("ovf_count_b", 32'(ovf1), 32'(mcnt));
            adv = (sb.size() < 2) || ifa.rsp_ready;
            g   = -1;
            if (adv) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (mptr + k) % N;
                    if (g < 0 && ifa.req_valid[idx]) g = idx;
                end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready_a", 32'(ifa.req_ready), 32'(exp_rdy));
            chk("req_ready_b", 32'(ifb.req_ready), 32'(exp_rdy));
            exp_v = (sb.size() > 0) && (cyc >= sb[0].acc + 2);
            chk("rsp_valid_a", 32'(ifa.rsp_valid), 32'(exp_v));
            chk("rsp_valid_b", 32'(ifb.rsp_valid), 32'(exp_v));
            if (hold) begin
                chk("stable_sum_a", ifa.rsp_sum, hs0);
                chk("stable_sum_b", ifb.rsp_sum, hs1);
                chk("stable_ovf", 32'(ifa.rsp_overflow), 32'(ho));
                chk("stable_id", 32'(ifa.rsp_id), 32'(hid));
            end
            if (exp_v && ifa.rsp_ready) begin
                e  = sb.pop_front();
                e0 = ref_sum(e.x, e.y, 1'b0, o);
                e1 = ref_sum(e.x, e.y, 1'b1, o);
                chk("rsp_sum_wrap", ifa.rsp_sum, e0);
                chk("rsp_sum_sat", ifb.rsp_sum, e1);
                chk("rsp_overflow_a", 32'(ifa.rsp_overflow), 32'(o));
                chk("rsp_overflow_b", 32'(ifb.rsp_overflow), 32'(o));
                chk("rsp_id_a", 32'(ifa.rsp_id), 32'(e.id));
                chk("rsp_id_b", 32'(ifb.rsp_id), 32'(e.id));
                if (o && mcnt < 65535) mcnt++;
                nresp++;
            end
            if (g >= 0) begin
                e.x   = ifa.req_x[32*g +: 32];
                e.y   = ifa.req_y[32*g +: 32];
                e.id  = g;
                e.acc = cyc;
                sb.push_back(e);
                gnt_log.push_back(g);
                mptr = g;
            end
            hold = ifa.rsp_valid && !ifa.rsp_ready;
            hs0  = ifa.rsp_sum;
            hs1  = ifb.rsp_sum;
            ho   = ifa.rsp_overflow;
            hid  = ifa.rsp_id;
        end
    end

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return {16'h7FFF, 16'($urandom)};
            1:       return {16'h8000, 16'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i);
        ifa.req_x[32*i +: 32] = rnd_op();
        ifa.req_y[32*i +: 32] = rnd_op();
    endtask

    // Accepted requesters get fresh operands and stay valid.
    task automatic refresh_keep();
        for (int i = 0; i < N; i++) if (acc_mask[i]) set_op(i);
    endtask

    // Accepted or idle requesters re-roll valid and operands.
    task automatic refresh_rand();
        for (int i = 0; i < N; i++) begin
            if (acc_mask[i] || !ifa.req_valid[i]) begin
                ifa.req_valid[i] = ($urandom_range(0, 2) != 0);
                set_op(i);
            end
        end
        ifa.rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic issue(input int i, input logic [31:0] x, input logic [31:0] y);
        bit ok;
        ok = 0;
        ifa.req_x[32*i +: 32] = x;
        ifa.req_y[32*i +: 32] = y;
        ifa.req_valid[i]      = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            step();
            ok = acc_mask[i];
        end
        chk("issue_accepted", 32'(ok), 32'h1);
        ifa.req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        ifa.req_valid = '0;
        ifa.rsp_ready = 1'b1;
        for (int n = 0; n < 40 && !ok; n++) begin
            step();
            ok = (sb.size() == 0) && !ifa.rsp_valid;
        end
        chk("drain_done", 32'(ok), 32'h1);
    endtask

    initial begin
        int base;
        int r0;
        ifa.req_valid = '0;
        ifa.req_x     = '0;
        ifa.req_y     = '0;
        ifa.rsp_ready = 1'b0;
        reset         = 1'b1;
        repeat (3) step();
        chk("reset_rsp_valid", 32'(ifa.rsp_valid), 32'h0);
        chk("reset_rsp_sum", ifa.rsp_sum, 32'h0);
        chk("reset_rsp_overflow", 32'(ifa.rsp_overflow), 32'h0);
        chk("reset_rsp_id", 32'(ifa.rsp_id), 32'h0);
        chk("reset_ovf_count", 32'(ovf0), 32'h0);

        reset         = 1'b0;
        ifa.rsp_ready = 1'b1;
        step();
        issue(1, 32'h00018000, 32'h00010000);
        issue(0, 32'h7FFF0000, 32'h00010000);
        issue(3, 32'h80000000, 32'hFFFF0000);
        issue(2, 32'h80000000, 32'h00010000);
        drain();
        chk("ovf_count_after_directed", 32'(ovf0), 32'd2);
        chk("ovf_count_sat_after_directed", 32'(ovf1), 32'd2);

        // Round-robin with all requesters valid from the first cycle after reset
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        base  = gnt_log.size();
        for (int i = 0; i < N; i++) begin
            ifa.req_valid[i] = 1'b1;
            set_op(i);
        end
        repeat (8) begin
            step();
            refresh_keep();
        end
        chk("rr_grant_count", 32'(gnt_log.size() >= base + 8), 32'h1);
        if (gnt_log.size() >= base + 8) begin
            for (int k = 0; k < 8; k++) chk("rr_order", 32'(gnt_log[base+k]), 32'(k % N));
        end
        drain();

        // Backpressure on requester 2
        ifa.rsp_ready    = 1'b0;
        base             = gnt_log.size();
        r0               = nresp;
        ifa.req_valid[2] = 1'b1;
        set_op(2);
        repeat (6) begin
            step();
            refresh_keep();
        end
        chk("bp_accepts", 32'(gnt_log.size() - base), 32'd2);
        chk("bp_ready_low", 32'(ifa.req_ready), 32'h0);
        ifa.rsp_ready = 1'b1;
        step();
        refresh_keep();
        ifa.rsp_ready = 1'b0;
        repeat (4) begin
            step();
            refresh_keep();
        end
        chk("bp_one_response", 32'(nresp - r0), 32'd1);
        chk("bp_one_more_accept", 32'(gnt_log.size() - base), 32'd3);

        // Reset while both stages are occupied
        ifa.req_valid = '0;
        reset         = 1'b1;
        step();
        chk("midreset_rsp_valid", 32'(ifa.rsp_valid), 32'h0);
        chk("midreset_ovf_count", 32'(ovf0), 32'h0);
        reset = 1'b0;
        base  = gnt_log.size();
        for (int i = 0; i < N; i++) begin
            ifa.req_valid[i] = 1'b1;
            set_op(i);
        end
        repeat (3) begin
            step();
            refresh_keep();
        end
        chk("midreset_got_grant", 32'(gnt_log.size() > base), 32'h1);
        if (gnt_log.size() > base) chk("midreset_first_grant", 32'(gnt_log[base]), 32'h0);
        drain();

        // Randomized traffic with random backpressure
        repeat (600) begin
            refresh_rand();
            step();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
